tpu_buf_loader: RTL and testbench

Host-side counterpart of the TPU datapath.
- Fills global buffers A and B from an inbound 32-bit valid/ready stream.
- Launches the TPU with K/M/N, then waits for ap_done.
- Reads global buffer C (128-bit entries) and emits each entry as four 32-bit words on an outbound valid/ready stream.
- Sits between the user-project bus adapter and the TPU/global-buffer subsystem.

---
 rtl/tpu_buf_loader.sv | 199 +++++++++++++++++++
 tb/tb_tpu_buf_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_buf_loader.sv
// Host-side job sequencer: streams A/B into the global buffers, launches the TPU, then drains C as 32-bit words.
// Optional WAIT watchdog compiled in with `define TPU_LDR_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module tpu_buf_loader #(
  parameter int ADDR_BITS      = 16,
  parameter int DATA_BITS      = 32,
  parameter int DATAC_BITS     = 128,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [7:0]            cfg_K,
  input  logic [7:0]            cfg_M,
  input  logic [7:0]            cfg_N,
  input  logic                  s_valid,
  input  logic [DATA_BITS-1:0]  s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_BITS-1:0]  m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  tpu_in_valid,
  output logic [7:0]            tpu_K,
  output logic [7:0]            tpu_M,
  output logic [7:0]            tpu_N,
  input  logic                  tpu_ap_done,
  output logic                  A_wr_en,
  output logic [ADDR_BITS-1:0]  A_index,
  output logic [DATA_BITS-1:0]  A_data_in,
  output logic                  B_wr_en,
  output logic [ADDR_BITS-1:0]  B_index,
  output logic [DATA_BITS-1:0]  B_data_in,
  output logic                  C_rd_en,
  output logic [ADDR_BITS-1:0]  C_index,
  input  logic [DATAC_BITS-1:0] C_data_out,
  output logic                  job_done,
  output logic                  job_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_UNLOAD_RD, S_UNLOAD_CAP, S_EMIT
  } state_t;

  state_t                 r_state, w_next;
  logic [ADDR_BITS-1:0]   r_cnt, r_la, r_lb, r_lc;
  logic [1:0]             r_w;
  logic                   r_job_done;
  logic [DATAC_BITS-1:0]  r_shreg;

  logic                   w_cfg_hs, w_zero, w_s_hs, w_m_hs;
  logic                   w_last_a, w_last_b, w_last_c, w_to_hit;
  logic [8:0]             w_cm4;
  logic [15:0]            w_la, w_lb, w_lc;

  // Buffer lengths come from the ceil(M/4) / ceil(N/4) tiling of the 4-lane array.
  assign w_cm4    = ({1'b0, cfg_M} + 9'd3) >> 2;
  assign w_la     = 16'(cfg_K) * 16'(w_cm4);
  assign w_lb     = 16'(cfg_K) * 16'((({1'b0, cfg_N} + 9'd3) >> 2));
  assign w_lc     = 16'(w_cm4) * 16'(cfg_N);

  assign w_cfg_hs = cfg_valid && (r_state == S_IDLE);
  assign w_zero   = (cfg_K == 8'd0) || (cfg_M == 8'd0) || (cfg_N == 8'd0);
  assign w_s_hs   = s_valid && ((r_state == S_LOAD_A) || (r_state == S_LOAD_B));
  assign w_m_hs   = m_ready && (r_state == S_EMIT);
  assign w_last_a = (r_cnt == r_la - 1'b1);
  assign w_last_b = (r_cnt == r_lb - 1'b1);
  assign w_last_c = (r_cnt == r_lc - 1'b1);
  assign job_done = r_job_done;

`ifdef TPU_LDR_TIMEOUT_EN
  logic [31:0] r_to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_to_cnt <= '0;
    else if (r_state != S_WAIT) r_to_cnt <= '0;
    else                        r_to_cnt <= r_to_cnt + 32'd1;
  end

  assign w_to_hit = (r_state == S_WAIT) && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign job_err  = w_to_hit && !tpu_ap_done;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
  assign w_to_hit         = 1'b0;
  assign job_err          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    cfg_ready    = 1'b0;
    s_ready      = 1'b0;
    A_wr_en      = 1'b0;
    A_index      = '0;
    A_data_in    = '0;
    B_wr_en      = 1'b0;
    B_index      = '0;
    B_data_in    = '0;
    tpu_in_valid = 1'b0;
    C_rd_en      = 1'b0;
    C_index      = '0;
    m_valid      = 1'b0;
    m_data       = '0;
    m_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (w_cfg_hs && !w_zero) w_next = S_LOAD_A;
      end
      S_LOAD_A: begin
        s_ready   = 1'b1;
        A_wr_en   = s_valid;
        A_index   = r_cnt;
        A_data_in = s_data;
        if (w_s_hs && w_last_a) w_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        s_ready   = 1'b1;
        B_wr_en   = s_valid;
        B_index   = r_cnt;
        B_data_in = s_data;
        if (w_s_hs && w_last_b) w_next = S_START;
      end
      S_START: begin
        tpu_in_valid = 1'b1;
        w_next       = S_WAIT;
      end
      S_WAIT: begin
        if (tpu_ap_done)   w_next = S_UNLOAD_RD;
        else if (w_to_hit) w_next = S_IDLE;
      end
      S_UNLOAD_RD: begin
        C_rd_en = 1'b1;
        C_index = r_cnt;
        w_next  = S_UNLOAD_CAP;
      end
      S_UNLOAD_CAP: w_next = S_EMIT;
      S_EMIT: begin
        m_valid = 1'b1;
        m_data  = r_shreg[DATA_BITS-1:0];
        m_last  = (r_w == 2'd3) && w_last_c;
        if (w_m_hs && (r_w == 2'd3)) w_next = w_last_c ? S_IDLE : S_UNLOAD_RD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_la       <= '0;
      r_lb       <= '0;
      r_lc       <= '0;
      r_w        <= '0;
      r_job_done <= 1'b0;
      tpu_K      <= '0;
      tpu_M      <= '0;
      tpu_N      <= '0;
    end else begin
      r_job_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_cfg_hs) begin
          tpu_K      <= cfg_K;
          tpu_M      <= cfg_M;
          tpu_N      <= cfg_N;
          r_la       <= ADDR_BITS'(w_la);
          r_lb       <= ADDR_BITS'(w_lb);
          r_lc       <= ADDR_BITS'(w_lc);
          r_cnt      <= '0;
          r_job_done <= w_zero;
        end
        S_LOAD_A: if (w_s_hs) r_cnt <= w_last_a ? '0 : r_cnt + 1'b1;
        S_LOAD_B: if (w_s_hs) r_cnt <= w_last_b ? '0 : r_cnt + 1'b1;
        S_WAIT:   if (tpu_ap_done) r_cnt <= '0;
        S_UNLOAD_CAP: r_w <= '0;
        S_EMIT: if (w_m_hs) begin
          r_w <= r_w + 2'd1;
          if (r_w == 2'd3) begin
            if (w_last_c) r_job_done <= 1'b1;
            else          r_cnt      <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Entry holder: loaded one cycle after the read strobe, shifted right one word per output handshake.
  always_ff @(posedge clk) begin
    if (r_state == S_UNLOAD_CAP) r_shreg <= C_data_out;
    else if (w_m_hs)             r_shreg <= r_shreg >> DATA_BITS;
  end

endmodule

// File: tb/tb_tpu_buf_loader.sv
// Scoreboard bench for tpu_buf_loader: models the global buffers and the TPU done pulse.
module tb_tpu_buf_loader;
  localparam int AB = 16;
  localparam int DB = 32;
  localparam int CB = 128;
  localparam int TO = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0, cfg_ready;
  logic [7:0]    cfg_K = '0, cfg_M = '0, cfg_N = '0;
  logic          s_valid = 1'b0, s_ready;
  logic [DB-1:0] s_data = '0;
  logic          m_valid, m_last, m_ready = 1'b1;
  logic [DB-1:0] m_data;
  logic          tpu_in_valid, tpu_ap_done;
  logic [7:0]    tpu_K, tpu_M, tpu_N;
  logic          A_wr_en, B_wr_en, C_rd_en;
  logic [AB-1:0] A_index, B_index, C_index;
  logic [DB-1:0] A_data_in, B_data_in;
  logic [CB-1:0] c_q = '0;
  logic          job_done, job_err;

  tpu_buf_loader #(.ADDR_BITS(AB), .DATA_BITS(DB), .DATAC_BITS(CB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_K(cfg_K), .cfg_M(cfg_M), .cfg_N(cfg_N),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .tpu_in_valid(tpu_in_valid), .tpu_K(tpu_K), .tpu_M(tpu_M), .tpu_N(tpu_N),
    .tpu_ap_done(tpu_ap_done),
    .A_wr_en(A_wr_en), .A_index(A_index), .A_data_in(A_data_in),
    .B_wr_en(B_wr_en), .B_index(B_index), .B_data_in(B_data_in),
    .C_rd_en(C_rd_en), .C_index(C_index), .C_data_out(c_q),
    .job_done(job_done), .job_err(job_err)
  );

  int n_checks = 0, n_fail = 0;
  int n_start = 0, n_done = 0, n_err = 0, n_crd = 0, n_mhs = 0, n_awr = 0, n_bwr = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] cword(input int e, input int w);
    return 32'hC000_0000 | 32'(e * 256 + w);
  endfunction

  function automatic logic [127:0] cmem(input logic [15:0] e);
    return {cword(int'(e), 3), cword(int'(e), 2), cword(int'(e), 1), cword(int'(e), 0)};
  endfunction

  // Global buffer C and TPU behavioural models
  always @(posedge clk) if (C_rd_en) c_q <= cmem(C_index);

  logic [3:0] ap_dly = '0;
  logic       ap_en = 1'b1, ap_force = 1'b0;
  always @(posedge clk) begin
    if (tpu_in_valid)      ap_dly <= 4'd5;
    else if (ap_dly != 0)  ap_dly <= ap_dly - 4'd1;
  end
  assign tpu_ap_done = (ap_en && ap_dly == 4'd1) || ap_force;

  logic [47:0] q_a[$], q_b[$];
  logic [32:0] q_m[$];

  // Monitor: pops the scoreboard on every buffer write and output handshake
  initial begin
    logic [47:0] ea;
    logic [32:0] em;
    logic        prev_stall;
    logic [DB-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (A_wr_en) begin
        n_awr++;
        if (q_a.size() == 0) check("A_extra_write", 1, 0);
        else begin
          ea = q_a.pop_front();
          check("A_index", A_index, ea[47:32]);
          check("A_data", A_data_in, ea[31:0]);
        end
      end
      if (B_wr_en) begin
        n_bwr++;
        if (q_b.size() == 0) check("B_extra_write", 1, 0);
        else begin
          ea = q_b.pop_front();
          check("B_index", B_index, ea[47:32]);
          check("B_data", B_data_in, ea[31:0]);
        end
      end
      if (C_rd_en) begin
        check("C_index", C_index, n_crd);
        n_crd++;
      end
      if (prev_stall) begin
        check("m_hold_valid", m_valid, 1);
        check("m_hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        n_mhs++;
        if (q_m.size() == 0) check("m_extra_word", 1, 0);
        else begin
          em = q_m.pop_front();
          check("m_data", m_data, em[31:0]);
          check("m_last", m_last, em[32]);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (tpu_in_valid) n_start++;
      if (job_done)     n_done++;
      if (job_err)      n_err++;
    end
  end

  task automatic push_ab(input int la, input int lb, input int base);
    for (int i = 0; i < la; i++) q_a.push_back({16'(i), 32'(base + i)});
    for (int i = 0; i < lb; i++) q_b.push_back({16'(i), 32'(base + la + i)});
  endtask

  task automatic send_cfg(input int k, input int m, input int n);
    @(negedge clk);
    check("cfg_ready_before_job", cfg_ready, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_K = 8'(k); cfg_M = 8'(m); cfg_N = 8'(n);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic feed(input int n, input int base);
    int  i = 0, guard = 0;
    bit  hs;
    s_valid = 1'b1;
    s_data  = 32'(base);
    while (i < n && guard < 200) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk); #1;
      if (hs) begin
        i++;
        s_data = 32'(base + i);
      end
      guard++;
    end
    s_valid = 1'b0;
    check("feed_words_accepted", i, n);
  endtask

  task automatic run_job(input int k, input int m, input int n, input bit toggle, input int base);
    int la, lb, lc, guard;
    la = k * ((m + 3) / 4);
    lb = k * ((n + 3) / 4);
    lc = ((m + 3) / 4) * n;
    push_ab(la, lb, base);
    for (int e = 0; e < lc; e++)
      for (int w = 0; w < 4; w++)
        q_m.push_back({(e == lc - 1 && w == 3), cword(e, w)});
    n_start = 0; n_done = 0; n_crd = 0; n_mhs = 0;
    send_cfg(k, m, n);
    feed(la + lb, base);
    guard = 0;
    while (n_done == 0 && guard < 2000) begin
      m_ready = toggle ? ~m_ready : 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("job_done_once", n_done, 1);
    check("tpu_start_once", n_start, 1);
    check("c_reads", n_crd, lc);
    check("out_handshakes", n_mhs, 4 * lc);
    check("scoreboard_a_empty", q_a.size(), 0);
    check("scoreboard_b_empty", q_b.size(), 0);
    check("scoreboard_m_empty", q_m.size(), 0);
    check("tpu_K_latched", tpu_K, k);
    check("tpu_M_latched", tpu_M, m);
    check("tpu_N_latched", tpu_N, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready, 1);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_tpu_in_valid"}, tpu_in_valid, 0);
    check({tag, "_tpu_KMN"}, {tpu_K, tpu_M, tpu_N}, 0);
    check({tag, "_A_wr_en"}, A_wr_en, 0);
    check({tag, "_B_wr_en"}, B_wr_en, 0);
    check({tag, "_B_index"}, B_index, 0);
    check({tag, "_C_rd_en"}, C_rd_en, 0);
    check({tag, "_C_index"}, C_index, 0);
    check({tag, "_job_done"}, job_done, 0);
    check({tag, "_job_err"}, job_err, 0);
  endtask

  initial begin
    int awr0, cnt;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // A done pulse outside WAIT must be ignored
    ap_force = 1'b1;
    @(posedge clk); #1;
    ap_force = 1'b0;
    @(negedge clk);
    check("stray_done_idle", cfg_ready, 1);
    check("stray_done_no_read", C_rd_en, 0);

    run_job(2, 4, 4, 1'b0, 1);
    run_job(2, 4, 4, 1'b1, 1);
    run_job(1, 5, 1, 1'b0, 32'h100);

    // Zero dimension: immediate completion, nothing else happens
    n_start = 0; n_done = 0; n_crd = 0; awr0 = n_awr;
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_K = 8'd0; cfg_M = 8'd4; cfg_N = 8'd4;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("zero_dim_done_pulse", job_done, 1);
    check("zero_dim_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    check("zero_dim_done_single", job_done, 0);
    repeat (5) @(negedge clk);
    check("zero_dim_no_start", n_start, 0);
    check("zero_dim_no_write", n_awr - awr0, 0);
    check("zero_dim_no_read", n_crd, 0);

    // Reset in LOAD_B after one of two B words
    push_ab(2, 1, 32'h200);
    send_cfg(2, 4, 4);
    feed(3, 32'h200);
    s_valid = 1'b1;
    s_data  = 32'hDEAD;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midjob_reset");
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midjob_b_consumed", q_b.size(), 0);
    run_job(2, 4, 4, 1'b0, 32'h300);

`ifdef TPU_LDR_TIMEOUT_EN
    ap_en = 1'b0;
    n_crd = 0; n_err = 0;
    push_ab(1, 1, 32'h400);
    send_cfg(1, 4, 4);
    feed(2, 32'h400);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!job_err && cnt < 300);
    check("timeout_latency", cnt, TO + 1);
    @(negedge clk);
    check("timeout_cfg_ready", cfg_ready, 1);
    check("timeout_no_read", n_crd, 0);
    check("timeout_err_once", n_err, 1);
    ap_en = 1'b1;
`else
    cnt = 0;
    check("job_err_never", n_err, cnt);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
